// File: rtl/input_event_pkg.sv
// Shared types for the input event arbiter.
package input_event_pkg;

  // ARB_IDLE: scanning pending bits; ARB_OFFER: one event held on the output port.
  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OFFER = 1'b1
  } arb_state_t;

endpackage

// File: rtl/debounce_cell.sv
// One debounce channel: accepts a level change on an already-synchronised input
// after DEBOUNCE_CYCLES consecutive differing cycles, and pulses edge_strobe once.
module debounce_cell #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic sync_in,
  output logic stable,
  output logic edge_strobe
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Count differing cycles; accept the new level on the last one and strobe the cycle after.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt         <= '0;
      stable      <= 1'b0;
      edge_strobe <= 1'b0;
    end else begin
      edge_strobe <= 1'b0;
      if (sync_in == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable      <= sync_in;
        cnt         <= '0;
        edge_strobe <= 1'b1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/input_event_arbiter.sv
// Debounced edge events from N async inputs, shared round-robin over one valid/ready port.
//
// Handshake: evt_valid/evt_idx/evt_level are held stable from the cycle evt_valid rises until
// the clock edge where evt_valid && evt_ready is seen; evt_valid drops the cycle after that edge.
module input_event_arbiter
  import input_event_pkg::*;
#(
  parameter  int N_INPUTS        = 4,
  parameter  int DEBOUNCE_CYCLES = 16,
  localparam int IDX_W           = $clog2(N_INPUTS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_INPUTS-1:0] async_in,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [IDX_W-1:0]    evt_idx,
  output logic                evt_level,
  output logic [N_INPUTS-1:0] pending,
  output logic [N_INPUTS-1:0] overflow,
  input  logic                clear_overflow
);

  logic [N_INPUTS-1:0] sync1, sync2, stable, strobe, plevel, clr_vec;
  logic [IDX_W-1:0]    ptr, grant_idx;
  logic                grant, take;
  arb_state_t          state, state_next;

  // Two-flop synchronizer per input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= async_in;
      sync2 <= sync1;
    end
  end

  for (genvar g = 0; g < N_INPUTS; g++) begin : g_db
    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk        (clk),
      .reset      (reset),
      .sync_in    (sync2[g]),
      .stable     (stable[g]),
      .edge_strobe(strobe[g])
    );
  end

  // Round-robin pick: first pending bit at or above ptr, wrapping; iterate backwards so the
  // smallest offset is the last (winning) assignment.
  always_comb begin
    int j;
    grant     = 1'b0;
    grant_idx = '0;
    j         = 0;
    for (int k = N_INPUTS - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N_INPUTS) j = j - N_INPUTS;
      if (pending[j]) begin
        grant     = 1'b1;
        grant_idx = IDX_W'(j);
      end
    end
  end

  // Arbiter state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ARB_IDLE;
    else        state <= state_next;
  end

  // Arbiter next state; take marks the cycle an event is latched out of pending.
  always_comb begin
    state_next = state;
    take       = 1'b0;
    case (state)
      ARB_IDLE:  if (grant) begin
                   state_next = ARB_OFFER;
                   take       = 1'b1;
                 end
      ARB_OFFER: if (evt_ready) state_next = ARB_IDLE;
      default:   state_next = ARB_IDLE;
    endcase
  end

  assign evt_valid = (state == ARB_OFFER);

  // One-hot of the pending bit the arbiter is clearing this cycle.
  always_comb begin
    clr_vec = '0;
    if (take) clr_vec[grant_idx] = 1'b1;
  end

  // Offered event registers and the rotating priority pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      evt_idx   <= '0;
      evt_level <= 1'b0;
      ptr       <= '0;
    end else if (take) begin
      evt_idx   <= grant_idx;
      evt_level <= plevel[grant_idx];
    end else if (evt_valid && evt_ready) begin
      ptr <= (evt_idx == IDX_W'(N_INPUTS - 1)) ? '0 : evt_idx + IDX_W'(1);
    end
  end

  // Pending/level/overflow per input. A new strobe beats the arbiter's clear and is not a loss
  // in that cycle; an overflow set beats clear_overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending  <= '0;
      plevel   <= '0;
      overflow <= '0;
    end else begin
      for (int i = 0; i < N_INPUTS; i++) begin
        if (strobe[i]) begin
          pending[i] <= 1'b1;
          plevel[i]  <= stable[i];
        end else if (clr_vec[i]) begin
          pending[i] <= 1'b0;
        end
        if (strobe[i] && pending[i] && !clr_vec[i]) overflow[i] <= 1'b1;
        else if (clear_overflow)                     overflow[i] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_input_event_arbiter.sv
// Bench for input_event_arbiter with N_INPUTS=4, DEBOUNCE_CYCLES=4.
module tb_input_event_arbiter;

  localparam int N = 4;
  localparam int D = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [N-1:0]  async_in = '0;
  logic          evt_ready = 1'b0;
  logic          clear_overflow = 1'b0;
  logic          evt_valid;
  logic [IW-1:0] evt_idx;
  logic          evt_level;
  logic [N-1:0]  pending;
  logic [N-1:0]  overflow;

  input_event_arbiter #(.N_INPUTS(N), .DEBOUNCE_CYCLES(D)) dut (
    .clk           (clk),
    .reset         (reset),
    .async_in      (async_in),
    .evt_valid     (evt_valid),
    .evt_ready     (evt_ready),
    .evt_idx       (evt_idx),
    .evt_level     (evt_level),
    .pending       (pending),
    .overflow      (overflow),
    .clear_overflow(clear_overflow)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  bit rand_ready = 1'b0;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rand_ready) evt_ready = ($urandom_range(3) != 0);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    async_in = '0;
    evt_ready = 1'b0;
    clear_overflow = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(2);
  endtask

  // Waits (bounded) for a handshake and checks the delivered event; returns at the
  // negedge just before the handshake edge.
  task automatic expect_evt(input string name, input int e_idx, input int e_lvl, output int cyc);
    bit ok;
    ok = 1'b0;
    cyc = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (evt_valid && evt_ready) begin
        ok = 1'b1;
        cyc = cycle;
        break;
      end
    end
    if (!ok) check({name, "_timeout"}, 0, 1);
    else begin
      check({name, "_idx"}, evt_idx, e_idx);
      check({name, "_lvl"}, evt_level, e_lvl);
    end
  endtask

  // ---------------- scoreboard (random phase) ----------------
  // Reference model: every accepted level change of input i is one event {i, level},
  // delivered in per-input order; glitches shorter than D cycles produce nothing.
  logic [IW:0] exp_q[$];
  bit          sb_en = 1'b0;
  bit          hold_prev = 1'b0;
  logic [IW:0] prev_evt = '0;
  int          sb_pos;

  always @(negedge clk) begin
    if (sb_en) begin
      if (hold_prev) begin
        check("sb_hold_valid", evt_valid, 1);
        check("sb_hold_evt", {evt_idx, evt_level}, prev_evt);
      end
      if (evt_valid && evt_ready) begin
        sb_pos = -1;
        for (int k = 0; k < exp_q.size(); k++)
          if (sb_pos < 0 && exp_q[k][IW:1] == evt_idx) sb_pos = k;
        if (sb_pos < 0) check("sb_event_expected", 0, 1);
        else begin
          check("sb_level", evt_level, exp_q[sb_pos][0]);
          exp_q.delete(sb_pos);
        end
      end
      hold_prev = evt_valid && !evt_ready;
      prev_evt  = {evt_idx, evt_level};
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [N-1:0] ain;
    int           exp_idx;
    int           exp_lvl;
  } vec_t;

  vec_t tbl[8];

  // ---------------- test sequence ----------------
  initial begin
    int lat, c1, c2, c3, cnt_v, cnt_p, start, ii, w;
    int last_act[N];

    tbl[0] = '{4'b0100, 2, 1};
    tbl[1] = '{4'b0000, 2, 0};
    tbl[2] = '{4'b0001, 0, 1};
    tbl[3] = '{4'b0000, 0, 0};
    tbl[4] = '{4'b1000, 3, 1};
    tbl[5] = '{4'b1010, 1, 1};
    tbl[6] = '{4'b0010, 3, 0};
    tbl[7] = '{4'b0000, 1, 0};

    // Reset state.
    tick(2);
    check("rst_valid", evt_valid, 0);
    check("rst_idx", evt_idx, 0);
    check("rst_level", evt_level, 0);
    check("rst_pending", pending, 0);
    check("rst_overflow", overflow, 0);
    reset = 1'b1;
    tick(2);

    // Asynchronous reset mid-run while an event is offered.
    evt_ready = 1'b0;
    async_in = 4'b0001;
    tick(10);
    async_in = 4'b0011;
    tick(10);
    check("t1_valid_before", evt_valid, 1);
    check("t1_pending_before", pending, 4'b0010);
    async_in = 4'b0001;
    tick(10);
    check("t1_overflow_before", overflow, 4'b0010);
    reset = 1'b0;
    #2;
    check("t1_valid_async", evt_valid, 0);
    check("t1_pending_async", pending, 0);
    check("t1_overflow_async", overflow, 0);
    async_in = '0;
    tick(3);
    reset = 1'b1;
    cnt_v = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (evt_valid) cnt_v++;
    end
    check("t1_quiet", cnt_v, 0);
    check("t1_quiet_pending", pending, 0);

    // Table: single-bit level changes with ready held high.
    evt_ready = 1'b1;
    for (int t = 0; t < 8; t++) begin
      async_in = tbl[t].ain;
      start = cycle;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (evt_valid) break;
      end
      lat = cycle - start;
      check($sformatf("tbl%0d_latency", t), (lat >= 8 && lat <= 9), 1);
      check($sformatf("tbl%0d_idx", t), evt_idx, tbl[t].exp_idx);
      check($sformatf("tbl%0d_lvl", t), evt_level, tbl[t].exp_lvl);
      tick();
      check($sformatf("tbl%0d_valid_drop", t), evt_valid, 0);
      check($sformatf("tbl%0d_pending_clr", t), pending[tbl[t].exp_idx], 0);
      tick(3);
    end

    // Glitch shorter than the debounce window is ignored.
    async_in[1] = 1'b1;
    tick(3);
    async_in[1] = 1'b0;
    cnt_v = 0;
    cnt_p = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (evt_valid) cnt_v++;
      if (pending[1]) cnt_p++;
    end
    check("t3_no_event", cnt_v, 0);
    check("t3_no_pending", cnt_p, 0);

    // Simultaneous rises: round-robin order and 2-cycle spacing.
    do_reset();
    evt_ready = 1'b1;
    async_in = 4'b1011;
    expect_evt("t4a_e0", 0, 1, c1);
    expect_evt("t4a_e1", 1, 1, c2);
    expect_evt("t4a_e2", 3, 1, c3);
    check("t4a_gap01", c2 - c1, 2);
    check("t4a_gap12", c3 - c2, 2);
    tick(3);
    async_in = 4'b0010;
    expect_evt("t4b_e0", 0, 0, c1);
    expect_evt("t4b_e1", 3, 0, c2);
    check("t4b_gap", c2 - c1, 2);

    // Stalled consumer: offer holds, pending overwrites and overflows, then drains.
    do_reset();
    async_in = 4'b0001;
    tick(10);
    check("t5_valid", evt_valid, 1);
    check("t5_idx", evt_idx, 0);
    check("t5_lvl", evt_level, 1);
    async_in = 4'b0000;
    tick(10);
    check("t5_pending_first", pending[0], 1);
    check("t5_no_overflow_first", overflow[0], 0);
    async_in = 4'b0001;
    tick(10);
    check("t5_hold_valid", evt_valid, 1);
    check("t5_hold_idx", evt_idx, 0);
    check("t5_hold_lvl", evt_level, 1);
    check("t5_pending", pending[0], 1);
    check("t5_overflow", overflow[0], 1);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check("t5_overflow_cleared", overflow[0], 0);
    evt_ready = 1'b1;
    expect_evt("t5_e0", 0, 1, c1);
    expect_evt("t5_e1", 0, 1, c2);
    tick();
    check("t5_pending_end", pending, 0);

    // Strobe on idx1 in the same cycle the arbiter latches idx1.
    do_reset();
    async_in = 4'b0001;
    tick(10);
    async_in = 4'b0011;
    tick(10);
    async_in = 4'b0001;
    tick(5);
    evt_ready = 1'b1;
    tick();
    check("t6_idle_gap", evt_valid, 0);
    tick();
    check("t6_valid_a", evt_valid, 1);
    check("t6_idx_a", evt_idx, 1);
    check("t6_lvl_a", evt_level, 1);
    check("t6_pending_kept", pending[1], 1);
    check("t6_no_overflow", overflow[1], 0);
    tick();
    check("t6_gap_b", evt_valid, 0);
    tick();
    check("t6_valid_b", evt_valid, 1);
    check("t6_idx_b", evt_idx, 1);
    check("t6_lvl_b", evt_level, 0);
    check("t6_pending_b", pending[1], 0);
    tick(2);
    check("t6_pending_end", pending, 0);
    check("t6_overflow_end", overflow, 0);

    // Randomized toggles and glitches against the event-level reference model.
    do_reset();
    for (int k = 0; k < N; k++) last_act[k] = -1000;
    rand_ready = 1'b1;
    sb_en = 1'b1;
    for (int it = 0; it < 400; it++) begin
      ii = $urandom_range(N - 1);
      if (cycle - last_act[ii] >= 60 && $urandom_range(1) == 1) begin
        async_in[ii] = ~async_in[ii];
        exp_q.push_back({IW'(ii), async_in[ii]});
        last_act[ii] = cycle;
      end else if (cycle - last_act[ii] >= 10) begin
        w = $urandom_range(D - 1, 1);
        async_in[ii] = ~async_in[ii];
        tick(w);
        async_in[ii] = ~async_in[ii];
        last_act[ii] = cycle;
      end
      tick($urandom_range(6, 1));
    end
    rand_ready = 1'b0;
    evt_ready = 1'b1;
    for (int k = 0; k < 300 && exp_q.size() != 0; k++) tick();
    tick(2);
    sb_en = 1'b0;
    check("rand_drain_empty", exp_q.size(), 0);
    check("rand_overflow", overflow, 0);
    check("rand_pending", pending, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
